// File: rtl/sysconf_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sysconf_pkg : shared parameter indices and arbiter state encoding      |
// | Revision    : 1.0                                                      |
// +-----------------------------------------------------------------------+
package sysconf_pkg;

    localparam logic [1:0] MEM_LIM_IX    = 2'd0;
    localparam logic [1:0] STACK_ORG_IX  = 2'd1;
    localparam logic [1:0] STACK_SIZE_IX = 2'd2;

    typedef enum logic [2:0] {
        ST_INIT_SEL = 3'd0,
        ST_INIT_RD  = 3'd1,
        ST_IDLE     = 3'd2,
        ST_CPU_LOCK = 3'd3,
        ST_AUX_SEL  = 3'd4,
        ST_AUX_RD   = 3'd5,
        ST_AUX_DONE = 3'd6
    } state_e;

endpackage
`default_nettype wire

// File: rtl/sysconf_arb.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sysconf_arb : boot-time shadow loader and CPU/aux arbiter for the      |
// |               select-then-read system configuration device             |
// | Revision    : 1.0                                                      |
// +-----------------------------------------------------------------------+
module sysconf_arb
    import sysconf_pkg::*;
#(
    parameter int unsigned LOCK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_stb,
    input  logic        cpu_we,
    input  logic [31:0] cpu_data_in,
    output logic [31:0] cpu_data_out,
    output logic        cpu_ack,
    input  logic        aux_req,
    input  logic [1:0]  aux_ix,
    output logic [31:0] aux_data,
    output logic        aux_ack,
    output logic        dev_stb,
    output logic        dev_we,
    output logic [31:0] dev_data_out,
    input  logic [31:0] dev_data_in,
    input  logic        dev_ack,
    output logic [31:0] cfg_mem_lim,
    output logic [31:0] cfg_stack_org,
    output logic [31:0] cfg_stack_size,
    output logic        cfg_valid
);

    localparam logic [7:0] c_timer_last = 8'(LOCK_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [1:0]  ix_q, ix_d;
    logic [31:0] mem_lim_q, mem_lim_d;
    logic [31:0] stack_org_q, stack_org_d;
    logic [31:0] stack_size_q, stack_size_d;
    logic        valid_q, valid_d;
    logic [31:0] aux_data_q, aux_data_d;
    logic [7:0]  timer_q, timer_d;
    logic        last_aux_q, last_aux_d;
    logic        cpu_hold_q, cpu_hold_d;

    logic        cpu_win;
    logic        aux_win;

    // A CPU transfer stalled by the device keeps its grant until acked.
    assign cpu_win = cpu_stb && (cpu_hold_q || !aux_req || last_aux_q);
    assign aux_win = aux_req && !cpu_win;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_INIT_SEL;
            ix_q         <= 2'd0;
            mem_lim_q    <= 32'd0;
            stack_org_q  <= 32'd0;
            stack_size_q <= 32'd0;
            valid_q      <= 1'b0;
            aux_data_q   <= 32'd0;
            timer_q      <= 8'd0;
            last_aux_q   <= 1'b0;
            cpu_hold_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ix_q         <= ix_d;
            mem_lim_q    <= mem_lim_d;
            stack_org_q  <= stack_org_d;
            stack_size_q <= stack_size_d;
            valid_q      <= valid_d;
            aux_data_q   <= aux_data_d;
            timer_q      <= timer_d;
            last_aux_q   <= last_aux_d;
            cpu_hold_q   <= cpu_hold_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ix_d         = ix_q;
        mem_lim_d    = mem_lim_q;
        stack_org_d  = stack_org_q;
        stack_size_d = stack_size_q;
        valid_d      = valid_q;
        aux_data_d   = aux_data_q;
        timer_d      = timer_q;
        last_aux_d   = last_aux_q;
        cpu_hold_d   = cpu_hold_q;
        dev_stb      = 1'b0;
        dev_we       = 1'b0;
        dev_data_out = 32'd0;
        cpu_ack      = 1'b0;
        cpu_data_out = 32'd0;

        case (state_q)
            ST_INIT_SEL: begin
                dev_stb      = 1'b1;
                dev_we       = 1'b1;
                dev_data_out = {30'd0, ix_q};
                if (dev_ack) state_d = ST_INIT_RD;
            end
            ST_INIT_RD: begin
                dev_stb = 1'b1;
                if (dev_ack) begin
                    case (ix_q)
                        MEM_LIM_IX:   mem_lim_d    = dev_data_in;
                        STACK_ORG_IX: stack_org_d  = dev_data_in;
                        default:      stack_size_d = dev_data_in;
                    endcase
                    if (ix_q == STACK_SIZE_IX) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b1;
                    end else begin
                        ix_d    = ix_q + 2'd1;
                        state_d = ST_INIT_SEL;
                    end
                end
            end
            ST_IDLE: begin
                cpu_hold_d = 1'b0;
                if (cpu_win) begin
                    dev_stb      = cpu_stb;
                    dev_we       = cpu_we;
                    dev_data_out = cpu_data_in;
                    cpu_ack      = dev_ack;
                    cpu_data_out = dev_data_in;
                    if (!dev_ack) begin
                        cpu_hold_d = 1'b1;
                    end else if (cpu_we) begin
                        state_d = ST_CPU_LOCK;
                        timer_d = 8'd0;
                    end else begin
                        last_aux_d = 1'b0;
                    end
                end else if (aux_win) begin
                    ix_d    = aux_ix;
                    state_d = ST_AUX_SEL;
                end
            end
            ST_CPU_LOCK: begin
                dev_stb      = cpu_stb;
                dev_we       = cpu_we;
                dev_data_out = cpu_data_in;
                cpu_ack      = dev_ack;
                cpu_data_out = dev_data_in;
                if (cpu_stb) begin
                    if (dev_ack) begin
                        if (cpu_we) begin
                            timer_d = 8'd0;
                        end else begin
                            state_d    = ST_IDLE;
                            last_aux_d = 1'b0;
                        end
                    end
                end else if (timer_q == c_timer_last) begin
                    state_d    = ST_IDLE;
                    last_aux_d = 1'b0;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            ST_AUX_SEL: begin
                dev_stb      = 1'b1;
                dev_we       = 1'b1;
                dev_data_out = {30'd0, ix_q};
                if (dev_ack) state_d = ST_AUX_RD;
            end
            ST_AUX_RD: begin
                dev_stb = 1'b1;
                if (dev_ack) begin
                    aux_data_d = dev_data_in;
                    state_d    = ST_AUX_DONE;
                end
            end
            ST_AUX_DONE: begin
                last_aux_d = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_INIT_SEL;
        endcase
    end

    assign aux_ack        = (state_q == ST_AUX_DONE);
    assign aux_data       = aux_data_q;
    assign cfg_mem_lim    = mem_lim_q;
    assign cfg_stack_org  = stack_org_q;
    assign cfg_stack_size = stack_size_q;
    assign cfg_valid      = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sysconf_arb.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_sysconf_arb : scenario bench for sysconf_arb with a device model    |
// | Revision       : 1.0                                                   |
// +-----------------------------------------------------------------------+
module tb_sysconf_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_stb = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_data_in = 32'd0;
    logic [31:0] cpu_data_out;
    logic        cpu_ack;
    logic        aux_req = 1'b0;
    logic [1:0]  aux_ix = 2'd0;
    logic [31:0] aux_data;
    logic        aux_ack;
    logic        dev_stb;
    logic        dev_we;
    logic [31:0] dev_data_out;
    logic [31:0] dev_data_in;
    logic        dev_ack;
    logic [31:0] cfg_mem_lim;
    logic [31:0] cfg_stack_org;
    logic [31:0] cfg_stack_size;
    logic        cfg_valid;

    logic        ack_en = 1'b1;
    logic [31:0] dev_reg = 32'd0;
    int          aux_ack_cnt = 0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    sysconf_arb #(.LOCK_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_stb(cpu_stb), .cpu_we(cpu_we), .cpu_data_in(cpu_data_in),
        .cpu_data_out(cpu_data_out), .cpu_ack(cpu_ack),
        .aux_req(aux_req), .aux_ix(aux_ix), .aux_data(aux_data), .aux_ack(aux_ack),
        .dev_stb(dev_stb), .dev_we(dev_we), .dev_data_out(dev_data_out),
        .dev_data_in(dev_data_in), .dev_ack(dev_ack),
        .cfg_mem_lim(cfg_mem_lim), .cfg_stack_org(cfg_stack_org),
        .cfg_stack_size(cfg_stack_size), .cfg_valid(cfg_valid)
    );

    function automatic logic [31:0] dev_param(input logic [1:0] ix);
        case (ix)
            2'd0:    return 32'h40000;
            2'd1:    return 32'h30000;
            2'd2:    return 32'h4000;
            default: return 32'h0;
        endcase
    endfunction

    // Device: select latches the addressed parameter, read presents it.
    assign dev_ack     = ack_en;
    assign dev_data_in = dev_reg;
    always @(posedge clk) begin
        if (dev_stb && dev_we && dev_ack) dev_reg <= dev_param(dev_data_out[1:0]);
    end

    always @(posedge clk) begin
        if (aux_ack) aux_ack_cnt <= aux_ack_cnt + 1;
    end

    task automatic cpu_xfer(input logic we, input logic [31:0] d,
                            output logic [31:0] rd, output logic ok);
        ok = 1'b0;
        rd = 32'd0;
        cpu_stb = 1'b1;
        cpu_we = we;
        cpu_data_in = d;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cpu_ack) begin
                rd = cpu_data_out;
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
        cpu_stb = 1'b0;
        cpu_we = 1'b0;
    endtask

    task automatic aux_wait(input int maxc, output int lat, output logic [31:0] d);
        lat = 0;
        d = 32'd0;
        for (int n = 1; n <= maxc; n++) begin
            @(negedge clk);
            if (aux_ack) begin
                lat = n;
                d = aux_data;
            end
            @(posedge clk);
            #1;
            if (lat != 0) break;
        end
        aux_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (cfg_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b want 0", cfg_valid); end
        total++; if (aux_ack !== 1'b0) begin bad++; $display("FAIL rst_aux_ack: got %0b want 0", aux_ack); end
        total++; if (aux_data !== 32'd0) begin bad++; $display("FAIL rst_aux_data: got %0h want 0", aux_data); end
        total++; if ({cfg_mem_lim, cfg_stack_org, cfg_stack_size} !== 96'd0) begin
            bad++; $display("FAIL rst_cfg: got %0h/%0h/%0h want 0/0/0", cfg_mem_lim, cfg_stack_org, cfg_stack_size); end
        total++; if ({dev_stb, dev_we, dev_data_out} !== {2'b11, 32'd0}) begin
            bad++; $display("FAIL rst_init_sel: got stb=%0b we=%0b d=%0h want 1 1 0", dev_stb, dev_we, dev_data_out); end
        rst = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            #1;
            total++;
            if (cfg_valid !== (e == 6)) begin
                bad++; $display("FAIL init_valid_edge%0d: got %0b want %0b", e, cfg_valid, (e == 6));
            end
        end
        total++; if (cfg_mem_lim !== 32'h40000) begin bad++; $display("FAIL cfg_mem_lim: got %0h want 40000", cfg_mem_lim); end
        total++; if (cfg_stack_org !== 32'h30000) begin bad++; $display("FAIL cfg_stack_org: got %0h want 30000", cfg_stack_org); end
        total++; if (cfg_stack_size !== 32'h4000) begin bad++; $display("FAIL cfg_stack_size: got %0h want 4000", cfg_stack_size); end
    endtask

    task automatic test_aux_single();
        int          lat = 0;
        logic [31:0] d = 32'd0;
        logic [31:0] exp;
        aux_ix = 2'd1;
        aux_req = 1'b1;
        exp_q.push_back(dev_param(2'd1));
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 2) begin
                total++; if ({dev_stb, dev_we, dev_data_out} !== {2'b11, 32'd1}) begin
                    bad++; $display("FAIL aux_sel_drive: got stb=%0b we=%0b d=%0h want 1 1 1", dev_stb, dev_we, dev_data_out); end
            end
            if (n == 3) begin
                total++; if ({dev_stb, dev_we} !== 2'b10) begin
                    bad++; $display("FAIL aux_rd_drive: got stb=%0b we=%0b want 1 0", dev_stb, dev_we); end
            end
            if (aux_ack) begin lat = n; d = aux_data; end
            @(posedge clk);
            #1;
            if (lat != 0) break;
        end
        aux_req = 1'b0;
        total++; if (lat != 4) begin bad++; $display("FAIL aux_latency: got %0d want 4", lat); end
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        total++; if (d !== exp) begin bad++; $display("FAIL aux_data_ix1: got %0h want %0h", d, exp); end
        @(negedge clk);
        total++; if (aux_ack !== 1'b0) begin bad++; $display("FAIL aux_ack_pulse: got %0b want 0", aux_ack); end
        total++; if (aux_data !== 32'h30000) begin bad++; $display("FAIL aux_data_hold: got %0h want 30000", aux_data); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_cpu_lock_read();
        logic [31:0] rd;
        logic        ok;
        int          cnt0, lat;
        logic [31:0] d, exp;
        cpu_xfer(1'b1, 32'd2, rd, ok);
        total++; if (!ok) begin bad++; $display("FAIL cpu_sel2_ack: got 0 want 1"); end
        aux_ix = 2'd0;
        aux_req = 1'b1;
        exp_q.push_back(dev_param(2'd0));
        cnt0 = aux_ack_cnt;
        @(posedge clk);
        #1;
        cpu_xfer(1'b0, 32'd0, rd, ok);
        total++; if (!ok || rd !== 32'h4000) begin bad++; $display("FAIL cpu_rd_locked: got %0h ok=%0b want 4000", rd, ok); end
        total++; if (aux_ack_cnt != cnt0) begin bad++; $display("FAIL aux_held_off: got %0d acks want 0", aux_ack_cnt - cnt0); end
        aux_wait(20, lat, d);
        total++; if (lat != 4) begin bad++; $display("FAIL aux_after_cpu_lat: got %0d want 4", lat); end
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        total++; if (d !== exp) begin bad++; $display("FAIL aux_after_cpu_data: got %0h want %0h", d, exp); end
    endtask

    task automatic test_lock_timeout();
        logic [31:0] rd;
        logic        ok;
        int          lat;
        logic [31:0] d, exp;
        cpu_xfer(1'b1, 32'd0, rd, ok);
        total++; if (!ok) begin bad++; $display("FAIL cpu_sel0_ack: got 0 want 1"); end
        aux_ix = 2'd1;
        aux_req = 1'b1;
        exp_q.push_back(dev_param(2'd1));
        // 4 lock cycles, IDLE grant, SEL, RD, DONE
        aux_wait(30, lat, d);
        total++; if (lat != 8) begin bad++; $display("FAIL lock_release_lat: got %0d want 8", lat); end
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        total++; if (d !== exp) begin bad++; $display("FAIL lock_aux_data: got %0h want %0h", d, exp); end
        cpu_xfer(1'b0, 32'd0, rd, ok);
        total++; if (!ok || rd !== 32'h30000) begin bad++; $display("FAIL cpu_rd_hazard: got %0h ok=%0b want 30000", rd, ok); end
    endtask

    task automatic test_back_to_back();
        int          ord[$];
        int          exp_ord[4] = '{1, 0, 1, 0};
        int          nc = 0, na = 0;
        logic        c, a;
        logic [31:0] exp;
        cpu_we = 1'b0;
        cpu_data_in = 32'd0;
        cpu_stb = 1'b1;
        aux_ix = 2'd2;
        aux_req = 1'b1;
        exp_q.push_back(dev_param(2'd2));
        exp_q.push_back(dev_param(2'd2));
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            c = cpu_ack;
            a = aux_ack;
            if (c) begin
                ord.push_back(0);
                total++; if (cpu_data_out !== 32'h4000) begin bad++; $display("FAIL b2b_cpu_data: got %0h want 4000", cpu_data_out); end
            end
            if (a) begin
                ord.push_back(1);
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                total++; if (aux_data !== exp) begin bad++; $display("FAIL b2b_aux_data: got %0h want %0h", aux_data, exp); end
            end
            @(posedge clk);
            #1;
            if (c) begin nc++; if (nc == 2) cpu_stb = 1'b0; end
            if (a) begin na++; if (na == 2) aux_req = 1'b0; end
            if (nc >= 2 && na >= 2) break;
        end
        cpu_stb = 1'b0;
        aux_req = 1'b0;
        total++; if (ord.size() != 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", ord.size()); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= ord.size() || ord[i] != exp_ord[i]) begin
                bad++; $display("FAIL b2b_order%0d: got %0d want %0d (1=aux)", i, (i < ord.size()) ? ord[i] : -1, exp_ord[i]);
            end
        end
    endtask

    task automatic test_stall_and_reset();
        int          lat = 0;
        int          cnt0;
        logic [31:0] d = 32'd0;
        logic [31:0] exp;
        aux_ix = 2'd0;
        aux_req = 1'b1;
        exp_q.push_back(dev_param(2'd0));
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n >= 3 && n <= 5) begin
                total++; if ({dev_stb, dev_we, aux_ack} !== 3'b100) begin
                    bad++; $display("FAIL stall_hold%0d: got stb=%0b we=%0b ack=%0b want 1 0 0", n, dev_stb, dev_we, aux_ack); end
            end
            if (aux_ack) begin lat = n; d = aux_data; end
            @(posedge clk);
            #1;
            if (n == 2) ack_en = 1'b0;
            if (n == 5) ack_en = 1'b1;
            if (lat != 0) break;
        end
        aux_req = 1'b0;
        ack_en = 1'b1;
        total++; if (lat != 7) begin bad++; $display("FAIL stall_latency: got %0d want 7", lat); end
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        total++; if (d !== exp) begin bad++; $display("FAIL stall_data: got %0h want %0h", d, exp); end

        @(posedge clk);
        #1;
        aux_ix = 2'd1;
        aux_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ack_en = 1'b0;
        cnt0 = aux_ack_cnt;
        @(negedge clk);
        rst = 1'b1;
        aux_req = 1'b0;
        #1;
        total++; if ({cfg_valid, aux_ack} !== 2'b00) begin
            bad++; $display("FAIL async_rst: got valid=%0b ack=%0b want 0 0", cfg_valid, aux_ack); end
        total++; if (cfg_mem_lim !== 32'd0) begin bad++; $display("FAIL async_rst_cfg: got %0h want 0", cfg_mem_lim); end
        ack_en = 1'b1;
        test_reset();
        total++; if (aux_ack_cnt != cnt0) begin bad++; $display("FAIL aborted_aux_ack: got %0d acks want 0", aux_ack_cnt - cnt0); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_aux_single();
        test_cpu_lock_read();
        test_lock_timeout();
        test_back_to_back();
        test_stall_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sysconf_arb.md
Name: sysconf_arb

Overview:
- Sequencer and arbiter in front of the system-configuration register device (select-write, then read protocol).
- After reset it fetches mem_lim, stack_org and stack_size autonomously into shadow outputs for hardware consumers such as the stack/heap monitors.
- It then shares the device between the CPU IO bus and one auxiliary requester.
- It keeps each select+read pair atomic, so a requester's select is never clobbered by the other requester.

Parameters:
- lock_timeout, 16: idle cycles (no cpu_stb) after a CPU select-write before the CPU lock is released; range 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cpu_stb  in  1  CPU IO strobe; CPU holds it until cpu_ack
- cpu_we  in  1  CPU write; a write is a select operation
- cpu_data_in  in  32  CPU write data; bits [1:0] = parameter index
- cpu_data_out  out  32  read data to CPU
- cpu_ack  out  1  CPU acknowledge, combinational
- aux_req  in  1  aux read request, level; held until aux_ack
- aux_ix  in  2  parameter index, sampled at grant
- aux_data  out  32  read result, registered; valid while aux_ack=1 and held afterwards
- aux_ack  out  1  one-cycle completion pulse
- dev_stb  out  1  device strobe
- dev_we  out  1  device write/select
- dev_data_out  out  32  to device data_in
- dev_data_in  in  32  from device data_out
- dev_ack  in  1  device acknowledge
- cfg_mem_lim  out  32  shadow of parameter 0
- cfg_stack_org  out  32  shadow of parameter 1
- cfg_stack_size  out  32  shadow of parameter 2
- cfg_valid  out  1  shadows loaded

Behaviour:
- Device timing:
  - A select cycle (dev_stb=1, dev_we=1) loads the device data register at the closing edge.
  - The following read cycle (dev_stb=1, dev_we=0) presents it on dev_data_in.
  - The arbiter samples dev_data_in at the closing edge of the read cycle.
- Any SEL or RD state holds (no advance) while dev_ack=0.
- Reset values (async): state=INIT_SEL, ix=0, all cfg_* and aux_data = 0, cfg_valid=0, aux_ack=0, lock timer=0, rr pointer=CPU-last.
- Combinational outputs are 0 unless stated: dev_*, cpu_ack, cpu_data_out.
- States: INIT_SEL, INIT_RD, IDLE, CPU_LOCK, AUX_SEL, AUX_RD, AUX_DONE.
- INIT_SEL/INIT_RD (ix 0..2):
  - INIT_SEL drives select with data={30'b0,ix}; INIT_RD drives a read.
  - INIT_RD writes dev_data_in into cfg[ix].
  - Sequence: ix=2 -> IDLE with cfg_valid<=1. Six cycles total when dev_ack=1.
  - cpu_ack=0 and aux_req ignored during INIT.
- IDLE arbitration, round-robin on last-served:
  - CPU wins if cpu_stb and (!aux_req or last=AUX).
  - Aux wins if aux_req and (!cpu_stb or last=CPU).
  - A lone requester always wins.
- CPU grant is pass-through in the same cycle:
  - dev_stb/dev_we/dev_data_out = cpu_*; cpu_ack=dev_ack; cpu_data_out=dev_data_in.
  - CPU read completing in IDLE: stay IDLE, last=CPU.
  - CPU select completing: go to CPU_LOCK, timer=0.
- CPU_LOCK:
  - CPU pass-through only; aux waits.
  - A CPU read completing -> IDLE, last=CPU.
  - A CPU select restarts the timer.
  - With cpu_stb=0 the timer increments; at timer=lock_timeout-1 -> IDLE, last=CPU.
- Aux grant:
  - aux_ix is latched on grant.
  - AUX_SEL drives select {30'b0,ix}, then AUX_RD drives a read and aux_data<=dev_data_in.
  - AUX_DONE asserts aux_ack=1 for one cycle, last=AUX -> IDLE.
  - aux_req still high in IDLE is a new request.
  - ix=3 completes normally; the device returns 0.
- Aux never preempts a CPU transfer already granted; CPU never interleaves inside AUX_SEL..AUX_DONE.
- cfg_* change only in INIT. CPU selects have no effect on the shadows.
- Reset mid-operation: immediate return to INIT_SEL ix=0, cfg_valid drops, pending aux aborted without ack.

Decomposition:
- Package sysconf_pkg holds:
  - parameter index constants MEM_LIM_IX=0, STACK_ORG_IX=1, STACK_SIZE_IX=2, shared with sysconf;
  - state encoding enum (3-bit).
- No sub-module. Lock timer and FSM live in one module, about 200 lines.

Test Plan:
- Reset, device defaults 'h40000/'h30000/'h4000 -> cfg_valid rises on the 6th edge after rst falls; cfg_* match the defaults.
- aux_req ix=1 alone in IDLE -> AUX_SEL, AUX_RD, then aux_ack pulse with aux_data='h30000, 3 cycles after grant.
- CPU select ix=2 then read 3 cycles later, with aux_req raised between them -> CPU reads 'h4000; aux served only after the CPU read; CPU result not corrupted.
- CPU select ix=0 then no strobe, lock_timeout=4 -> lock released after 4 idle cycles; pending aux served; CPU's later read returns aux's selected value (documented hazard).
- cpu_stb and aux_req simultaneous in IDLE after a CPU-last transfer -> aux granted first, CPU next; strict alternation over 4 back-to-back requests.
- dev_ack held 0 for 3 cycles in AUX_RD -> state held, aux_ack delayed 3 cycles; rst pulsed in AUX_RD -> no aux_ack, cfg_valid=0, INIT restarts.
